riscv_muldiv: RTL and testbench

Iterative RV32M multiply/divide unit, parametrised in operand width, executing all eight M-extension operations with a radix-2, one-bit-per-cycle datapath. Sits beside `riscv_alu` in the execute stage: the core issues a request through a valid/ready handshake, stalls on `busy`, and collects the result through a second valid/ready handshake. It adds the multi-cycle sequencing, signed/unsigned modes and RISC-V corner-case results that the single-cycle adder path does not provide.

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/riscv_muldiv_addsub.sv | 22 ++
 rtl/riscv_muldiv.sv | 177 +++++++++++++++++
 tb/tb_riscv_muldiv.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32M types: funct3 op encoding and the mul/div FSM states.
package riscv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } muldiv_state_t;

endpackage

// File: rtl/riscv_muldiv_addsub.sv
// Combinational add/subtract with carry-out.
// Shared by the multiply and divide iterations.
module muldiv_addsub #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] r;

  assign r = {1'b0, a}
           + {1'b0, sub ? ~b : b}
           + {{W{1'b0}}, sub};

  assign sum  = r[W-1:0];
  assign cout = r[W];

endmodule

// File: rtl/riscv_muldiv.sv
// Iterative radix-2 RV32M multiply/divide unit.
// Shift-add multiply, restoring divide, one bit per cycle.
import riscv_pkg::*;

module riscv_muldiv #(
  parameter int XLEN      = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            busy
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG =
    {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t     state_q, state_d;
  muldiv_op_t        op_q, op_in;
  logic [2*XLEN-1:0] acc_q, acc_nxt, prod;
  logic [XLEN-1:0]   a_q, b_q, ma, mb;
  logic [XLEN-1:0]   quo, rem, res;
  logic [CW-1:0]     cnt_q;
  logic              fin_q, neg_q, dz_q, ov_q;
  logic              sgn_a, sgn_b, sa, sb;
  logic              neg_in, dz_in, ov_in;
  logic              accept;
  logic [XLEN:0]     as_a, as_b, as_sum;
  logic              as_sub, as_cout;

  assign accept = req_valid & req_ready;

  // operand sign decode and magnitude conversion
  always_comb begin
    op_in = muldiv_op_t'(req_op);
    sgn_a = 1'b0;
    sgn_b = 1'b0;
    unique case (op_in)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
        sgn_a = 1'b1;
        sgn_b = 1'b1;
      end
      OP_MULHSU: sgn_a = 1'b1;
      default: ;
    endcase
    sa     = sgn_a & req_a[XLEN-1];
    sb     = sgn_b & req_b[XLEN-1];
    ma     = sa ? -req_a : req_a;
    mb     = sb ? -req_b : req_b;
    neg_in = (req_op[2] & req_op[1]) ? sa : sa ^ sb;
    dz_in  = req_op[2] & ~|req_b;
    ov_in  = sgn_a & req_op[2]
           & (req_a == MIN_NEG) & (&req_b);
  end

  always_comb begin
    if (op_q[2]) begin
      as_a   = acc_q[2*XLEN-1:XLEN-1];
      as_b   = {1'b0, b_q};
      as_sub = 1'b1;
    end else begin
      as_a   = {1'b0, acc_q[2*XLEN-1:XLEN]};
      as_b   = {1'b0, acc_q[0] ? b_q : '0};
      as_sub = 1'b0;
    end
  end

  muldiv_addsub #(.W(XLEN+1)) u_addsub (
    .a    (as_a),
    .b    (as_b),
    .sub  (as_sub),
    .sum  (as_sum),
    .cout (as_cout)
  );

  always_comb begin
    if (!op_q[2])
      acc_nxt = {as_sum, acc_q[XLEN-1:1]};
    else if (as_cout)
      acc_nxt = {as_sum[XLEN-1:0],
                 acc_q[XLEN-2:0], 1'b1};
    else
      acc_nxt = {acc_q[2*XLEN-2:0], 1'b0};
  end

  // sign correction and RISC-V corner-case results
  always_comb begin
    prod = neg_q ? -acc_q : acc_q;
    quo  = acc_q[XLEN-1:0];
    rem  = acc_q[2*XLEN-1:XLEN];
    unique case (op_q)
      OP_MUL:            res = prod[XLEN-1:0];
      OP_DIV, OP_DIVU:   res = neg_q ? -quo : quo;
      OP_REM, OP_REMU:   res = neg_q ? -rem : rem;
      default:           res = prod[2*XLEN-1:XLEN];
    endcase
    if (dz_q)
      res = op_q[1] ? a_q : '1;
    else if (ov_q)
      res = op_q[1] ? '0 : a_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        state_q <= S_IDLE;
    else if (flush) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (req_valid)  state_d = S_CALC;
      S_CALC:  if (fin_q)      state_d = S_DONE;
      S_DONE:  if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q       <= OP_MUL;
      acc_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      cnt_q      <= '0;
      fin_q      <= 1'b0;
      neg_q      <= 1'b0;
      dz_q       <= 1'b0;
      ov_q       <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
    end else if (flush) begin
      fin_q      <= 1'b0;
      resp_valid <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: if (accept) begin
          op_q  <= op_in;
          a_q   <= req_a;
          b_q   <= mb;
          acc_q <= {{XLEN{1'b0}}, ma};
          cnt_q <= CW'(XLEN - 1);
          neg_q <= neg_in;
          dz_q  <= dz_in;
          ov_q  <= ov_in;
          fin_q <= EARLY_OUT & (dz_in | ov_in);
        end
        S_CALC: if (fin_q) begin
          fin_q      <= 1'b0;
          resp_data  <= res;
          resp_valid <= 1'b1;
        end else begin
          acc_q <= acc_nxt;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) fin_q <= 1'b1;
        end
        S_DONE: if (resp_ready) resp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_muldiv.sv
// Directed-vector bench for riscv_muldiv (XLEN=32, EARLY_OUT=1).
module tb_riscv_muldiv;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_data;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  riscv_muldiv #(.XLEN(32), .EARLY_OUT(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Issue one op from IDLE, return result and accept-to-valid latency.
  task automatic run_op(input logic [2:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        output logic [31:0] d,
                        output int lat);
    req_op = op; req_a = a; req_b = b;
    req_valid = 1'b1; resp_ready = 1'b1;
    d = '0; lat = -1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (resp_valid) begin
        lat = k; d = resp_data;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic run_table(input vec_t v[]);
    logic [31:0] d;
    int lat;
    foreach (v[i]) begin
      run_op(v[i].op, v[i].a, v[i].b, d, lat);
      n_checks++;
      if (d !== v[i].exp) begin
        n_errors++;
        $display("FAIL %s data: got %h want %h",
                 v[i].name, d, v[i].exp);
      end
      n_checks++;
      if (lat != v[i].lat) begin
        n_errors++;
        $display("FAIL %s latency: got %0d want %0d",
                 v[i].name, lat, v[i].lat);
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    n_checks += 4;
    if (req_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_req_ready: got %b want 1", req_ready);
    end
    if (resp_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_resp_valid: got %b want 0", resp_valid);
    end
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
    if (resp_data !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_resp_data: got %h want 0", resp_data);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mul;
    vec_t v[] = '{
      '{"mul_7x6",     3'd0, 32'd7, 32'd6, 32'h0000002A, 33},
      '{"mulhu_ffxff", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF,
        32'hFFFFFFFE, 33},
      '{"mulh_min",    3'd1, 32'h80000000, 32'h80000000,
        32'h40000000, 33},
      '{"mulhsu_ffxff", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF,
        32'hFFFFFFFF, 33},
      '{"mul_neg",     3'd0, 32'hFFFFFFFD, 32'd5,
        32'hFFFFFFF1, 33}
    };
    run_table(v);
  endtask

  task automatic test_div;
    vec_t v[] = '{
      '{"div_m7_2",  3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33},
      '{"rem_m7_2",  3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33},
      '{"divu_100_7", 3'd5, 32'd100, 32'd7, 32'd14, 33},
      '{"remu_100_7", 3'd7, 32'd100, 32'd7, 32'd2, 33},
      '{"div_7_m2",  3'd4, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 33},
      '{"rem_7_m2",  3'd6, 32'd7, 32'hFFFFFFFE, 32'd1, 33}
    };
    run_table(v);
  endtask

  task automatic test_special;
    vec_t v[] = '{
      '{"div_by0",   3'd4, 32'h12345678, 32'd0, 32'hFFFFFFFF, 1},
      '{"rem_by0",   3'd6, 32'h12345678, 32'd0, 32'h12345678, 1},
      '{"divu_by0",  3'd5, 32'h12345678, 32'd0, 32'hFFFFFFFF, 1},
      '{"remu_by0",  3'd7, 32'h12345678, 32'd0, 32'h12345678, 1},
      '{"div_neg_by0", 3'd4, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 1},
      '{"rem_neg_by0", 3'd6, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 1},
      '{"div_ovf",   3'd4, 32'h80000000, 32'hFFFFFFFF,
        32'h80000000, 1},
      '{"rem_ovf",   3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1}
    };
    run_table(v);
  endtask

  task automatic test_hold;
    int lat;
    logic [31:0] d;
    req_op = 3'd0; req_a = 32'd5; req_b = 32'd5;
    req_valid = 1'b1; resp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (resp_valid) begin lat = k; break; end
    end
    n_checks++;
    if (lat != 33) begin
      n_errors++;
      $display("FAIL hold_latency: got %0d want 33", lat);
    end
    req_op = 3'd0; req_a = 32'd3; req_b = 32'd4;
    req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_checks += 2;
      if (resp_valid !== 1'b1 || resp_data !== 32'd25) begin
        n_errors++;
        $display("FAIL hold_data c%0d: got v=%b %h want v=1 %h",
                 i, resp_valid, resp_data, 32'd25);
      end
      if (req_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL hold_req_ready c%0d: got %b want 0",
                 i, req_ready);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    n_checks += 2;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL release_idle: got rdy=%b busy=%b want 1 0",
               req_ready, busy);
    end
    if (resp_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL release_valid: got %b want 0", resp_valid);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++;
      $display("FAIL accept_after_done: got busy=%b want 1", busy);
    end
    lat = -1; d = '0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (resp_valid) begin lat = k; d = resp_data; break; end
    end
    n_checks += 2;
    if (d !== 32'd12) begin
      n_errors++;
      $display("FAIL next_after_hold data: got %h want %h", d, 32'd12);
    end
    if (lat != 33) begin
      n_errors++;
      $display("FAIL next_after_hold latency: got %0d want 33", lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int k1, k2;
    logic [31:0] d1, d2;
    k1 = -1; k2 = -1; d1 = '0; d2 = '0;
    req_op = 3'd0; req_a = 32'd2; req_b = 32'd3;
    req_valid = 1'b1; resp_ready = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (resp_valid) begin
        if (k1 < 0) begin k1 = k; d1 = resp_data; end
        else begin k2 = k; d2 = resp_data; break; end
      end
    end
    req_valid = 1'b0;
    n_checks += 4;
    if (k1 != 33) begin
      n_errors++;
      $display("FAIL b2b_first_latency: got %0d want 33", k1);
    end
    if (k2 - k1 != 35) begin
      n_errors++;
      $display("FAIL b2b_period: got %0d want 35", k2 - k1);
    end
    if (d1 !== 32'd6) begin
      n_errors++;
      $display("FAIL b2b_data1: got %h want %h", d1, 32'd6);
    end
    if (d2 !== 32'd6) begin
      n_errors++;
      $display("FAIL b2b_data2: got %h want %h", d2, 32'd6);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_flush_rst;
    logic seen;
    logic [31:0] d;
    int lat;
    req_op = 3'd0; req_a = 32'd100; req_b = 32'd100;
    req_valid = 1'b1; resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_checks += 3;
    if (req_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL flush_req_ready: got %b want 1", req_ready);
    end
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_busy: got %b want 0", busy);
    end
    if (resp_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_resp_valid: got %b want 0", resp_valid);
    end
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (resp_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_discard: got resp_valid=1 want 0");
    end
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (19) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_checks += 4;
    if (req_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_req_ready: got %b want 1", req_ready);
    end
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_busy: got %b want 0", busy);
    end
    if (resp_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_resp_valid: got %b want 0", resp_valid);
    end
    if (resp_data !== 32'h0) begin
      n_errors++;
      $display("FAIL rst_resp_data: got %h want 0", resp_data);
    end
    #2 rst = 1'b0;
    run_op(3'd0, 32'd3, 32'd3, d, lat);
    n_checks += 2;
    if (d !== 32'd9) begin
      n_errors++;
      $display("FAIL after_rst_mul data: got %h want %h", d, 32'd9);
    end
    if (lat != 33) begin
      n_errors++;
      $display("FAIL after_rst_mul latency: got %0d want 33", lat);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_hold();
    test_back_to_back();
    test_flush_rst();
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
